axi_word_gather: RTL and testbench
==================================

# axi_word_gather

Upstream stage of the width trimmer in the AXI read path. Accepts AXI R-channel beats of `BEAT_WIDTH` bits, slices each into `IN_WIDTH`-bit words and packs `DATA_COUNT` words into one flat vector. Each completed vector is presented on a valid/ready output whose data port connects directly to the trimmer input. The block is double-buffered, so it sustains one beat per cycle while the consumer keeps `m_ready` high.

## Interface

Parameters:

- `BEAT_WIDTH`, 128: AXI R data width. Must be a multiple of `IN_WIDTH`.
- `IN_WIDTH`, 64: word width. Matches the trimmer's `IN_WIDTH`.
- `DATA_COUNT`, 8: words per output vector. Must be a multiple of `BEAT_WIDTH/IN_WIDTH`.

Derived constants:

- `WPB = BEAT_WIDTH/IN_WIDTH`: words per beat.
- `BPV = DATA_COUNT/WPB`: beats per vector.

Ports:

- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_rvalid` in 1: beat valid.
- `s_rready` out 1: beat accepted when `s_rvalid & s_rready`.
- `s_rdata` in `BEAT_WIDTH`: beat data.
- `s_rresp` in 2: AXI response.
- `s_rlast` in 1: last beat of burst.
- `m_valid` out 1: vector valid.
- `m_ready` in 1: consumer ready.
- `m_data` out `DATA_COUNT*IN_WIDTH`: packed vector. Word i is at `[i*IN_WIDTH +: IN_WIDTH]`.
- `m_count` out `$clog2(DATA_COUNT+1)`: number of valid words in `m_data`.
- `m_err` out 1: a non-OKAY response was seen in this vector.

## Operation

- Fill buffer holds `fill_data`, `fill_cnt` (beats, 0..BPV-1), `fill_err` and `fill_done`.
- Output buffer holds `m_data`, `m_count`, `m_err` and `m_valid`.
- Beat placement:
  - An accepted beat with `fill_cnt = k` writes words `k*WPB .. k*WPB+WPB-1`.
  - Beat word j is `s_rdata[j*IN_WIDTH +: IN_WIDTH]`.
- A vector completes on the accepting beat when `fill_cnt = BPV-1` or `s_rlast = 1`.
- Partial vector (early `s_rlast`):
  - Words above `(k+1)*WPB-1` are driven to zero.
  - `m_count = (k+1)*WPB`.
- Output slot free means `!m_valid | m_ready`.
- On completion:
  - If the output slot is free, the vector is loaded into the output buffer on the same edge.
  - Otherwise the fill buffer sets `fill_done` and holds the vector.
- While `fill_done = 1`:
  - `s_rready = 0`.
  - The held vector moves to the output buffer on the first cycle the output slot is free. `fill_done` then clears.
- Otherwise `s_rready = 1`.
- After a vector moves out, the fill buffer restarts: `fill_cnt = 0`, `fill_data = 0`, `fill_err = 0`.
- Output buffer:
  - `m_valid` clears on `m_valid & m_ready` unless a new vector loads on the same edge.
  - `m_data`, `m_count` and `m_err` are stable while `m_valid & !m_ready`.
- Reset mid-burst:
  - Discards the partial fill and any held vector.
  - No output is emitted for a discarded partial burst.

## Timing

- Reset values:
  - `s_rready = 1`, `m_valid = 0`, `m_data = 0`, `m_count = 0`, `m_err = 0`.
  - `fill_cnt = 0`, `fill_done = 0`.
- Latency: vector-completing beat accepted at edge N gives `m_valid = 1` from cycle N+1.
- Throughput: one beat per cycle with `m_ready` tied high; no bubbles between vectors.
- `s_rready` is combinational from `fill_done` only. There is no combinational path from `m_ready` to `s_rready`.
- `m_valid`, `m_data`, `m_count` and `m_err` are registered outputs.
- Simultaneous output drain and fill completion in the same cycle: the new vector loads, and `m_valid` stays 1.

## Configuration

- Macro: `AXI_WORD_GATHER_RESP_CHECK_EN`.
- Defined:
  - Any accepted beat with `s_rresp != 2'b00` sets `fill_err`.
  - `fill_err` transfers to `m_err` with its vector.
- Undefined:
  - `s_rresp` is ignored.
  - `m_err` is constant 0.
  - No `fill_err` register is built.

## Structure

- Shared package `axi_gather_pkg` holds:
  - `AXI_RESP_OKAY = 2'b00`.
  - Function `wpb(beat_w, in_w)`.
  - Function `bpv(count, wpb)`.
  - Typedef for the count width.
- Single module; no sub-module. The fill buffer and output buffer are inline register sets.
- Elaboration-time checks: error if `BEAT_WIDTH % IN_WIDTH != 0` or `DATA_COUNT % WPB != 0`.

## Test plan

All scenarios use defaults (`WPB = 2`, `BPV = 4`) unless stated otherwise.

- **Full vector:** 4 back-to-back beats with word values 0..7 and `m_ready = 1` -> one vector, word i = i, `m_count = 8`, `m_valid` asserted the cycle after beat 4.
- **Partial burst:** 2 beats with `s_rlast` on beat 2 -> `m_count = 4`, words 4..7 = 0; the next burst starts at word 0.
- **Backpressure:** `m_ready = 0` while 8 beats are offered -> first vector held stable, `s_rready` drops after beat 8, zero beats lost. `m_ready = 1` -> both vectors delivered in order on consecutive cycles.
- **Streaming:** 64 beats continuous with `m_ready = 1` -> 16 vectors, `s_rready` never low.
- **Error response:** `s_rresp = 2'b10` on beat 3 with the macro defined -> that vector has `m_err = 1` and the next has `m_err = 0`. Without the macro -> `m_err = 0` throughout.
- **Reset mid-operation:** `rst` after 3 beats -> no vector emitted; a fresh 4-beat burst produces a correct vector with `m_count = 8`.

Source files
------------

// File: rtl/axi_gather_pkg.sv
// Shared constants, helper functions and count type for the AXI word gatherer.
package axi_gather_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         COUNT_W       = 16;

    typedef logic [COUNT_W-1:0] count_t;

    function automatic int wpb(input int beat_w, input int in_w);
        return beat_w / in_w;
    endfunction

    function automatic int bpv(input int count, input int wpb_n);
        return count / wpb_n;
    endfunction

endpackage

// File: rtl/axi_word_gather.sv
// Packs AXI R beats into DATA_COUNT-word vectors using a fill buffer plus an output buffer.
// Optional response checking is enabled with AXI_WORD_GATHER_RESP_CHECK_EN.
module axi_word_gather
    import axi_gather_pkg::*;
#(
    parameter int BEAT_WIDTH = 128,
    parameter int IN_WIDTH   = 64,
    parameter int DATA_COUNT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    input  logic [BEAT_WIDTH-1:0]          s_rdata,
    input  logic [1:0]                     s_rresp,
    input  logic                           s_rlast,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_COUNT*IN_WIDTH-1:0] m_data,
    output logic [$clog2(DATA_COUNT+1)-1:0] m_count,
    output logic                           m_err
);

    localparam int WPB = wpb(BEAT_WIDTH, IN_WIDTH);
    localparam int BPV = bpv(DATA_COUNT, WPB);
    localparam int VW  = DATA_COUNT * IN_WIDTH;
    localparam int CW  = $clog2(DATA_COUNT + 1);
    localparam int FCW = (BPV > 1) ? $clog2(BPV) : 1;

    if (BEAT_WIDTH % IN_WIDTH != 0) begin : g_chk_beat
        $error("axi_word_gather: BEAT_WIDTH must be a multiple of IN_WIDTH");
    end
    if (DATA_COUNT % WPB != 0) begin : g_chk_count
        $error("axi_word_gather: DATA_COUNT must be a multiple of BEAT_WIDTH/IN_WIDTH");
    end

    logic [VW-1:0]  r_fill_data;
    logic [FCW-1:0] r_fill_cnt;
    logic           r_fill_done;
    logic           r_m_valid;
    logic [VW-1:0]  r_m_data;
    logic [CW-1:0]  r_m_count;

    logic [VW-1:0]  w_fill_next;
    count_t         w_cnt_full;
    logic           w_accept;
    logic           w_complete;
    logic           w_slot_free;
    logic           w_load_held;
    logic           w_load_new;
    logic           w_fill_err_cur;
    logic           w_fill_err_next;
    logic           w_unused;

    assign s_rready    = !r_fill_done;
    assign w_accept    = s_rvalid && !r_fill_done;
    assign w_slot_free = !r_m_valid || m_ready;
    assign w_complete  = w_accept && ((r_fill_cnt == FCW'(BPV - 1)) || s_rlast);
    assign w_load_held = r_fill_done && w_slot_free;
    assign w_load_new  = w_complete && w_slot_free;

    // Words above the current beat stay zero because the fill buffer restarts cleared.
    always_comb begin
        w_fill_next = r_fill_data;
        for (int j = 0; j < WPB; j++) begin
            w_fill_next[(int'(r_fill_cnt) * WPB + j) * IN_WIDTH +: IN_WIDTH] =
                s_rdata[j * IN_WIDTH +: IN_WIDTH];
        end
    end

    // fill_cnt is frozen while a vector is held, so the same count serves both load paths.
    assign w_cnt_full = count_t'((int'(r_fill_cnt) + 1) * WPB);

`ifdef AXI_WORD_GATHER_RESP_CHECK_EN
    logic r_fill_err;
    logic r_m_err;

    assign w_fill_err_cur  = r_fill_err;
    assign w_fill_err_next = r_fill_err || (s_rresp != AXI_RESP_OKAY);
    assign m_err           = r_m_err;
    assign w_unused        = ^w_cnt_full[COUNT_W-1:CW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_err <= 1'b0;
        end else if (w_load_held || w_load_new) begin
            r_fill_err <= 1'b0;
        end else if (w_accept) begin
            r_fill_err <= w_fill_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_err <= 1'b0;
        end else if (w_load_held) begin
            r_m_err <= w_fill_err_cur;
        end else if (w_load_new) begin
            r_m_err <= w_fill_err_next;
        end
    end
`else
    assign w_fill_err_cur  = 1'b0;
    assign w_fill_err_next = 1'b0;
    assign m_err           = 1'b0;
    assign w_unused        = ^{s_rresp, w_cnt_full[COUNT_W-1:CW], w_fill_err_cur, w_fill_err_next};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_data <= '0;
            r_fill_cnt  <= '0;
            r_fill_done <= 1'b0;
        end else if (w_load_held || w_load_new) begin
            r_fill_data <= '0;
            r_fill_cnt  <= '0;
            r_fill_done <= 1'b0;
        end else if (w_complete) begin
            r_fill_data <= w_fill_next;
            r_fill_done <= 1'b1;
        end else if (w_accept) begin
            r_fill_data <= w_fill_next;
            r_fill_cnt  <= r_fill_cnt + FCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_count <= '0;
        end else if (w_load_held) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_fill_data;
            r_m_count <= w_cnt_full[CW-1:0];
        end else if (w_load_new) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_fill_next;
            r_m_count <= w_cnt_full[CW-1:0];
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_count = r_m_count;

endmodule

// File: tb/tb_axi_word_gather.sv
// Directed self-checking bench for axi_word_gather at default parameters.
module tb_axi_word_gather;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_rvalid;
    logic         s_rready;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         m_valid;
    logic         m_ready;
    logic [511:0] m_data;
    logic [3:0]   m_count;
    logic         m_err;

    int errors = 0;
    int checks = 0;

    axi_word_gather dut (
        .clk      (clk),
        .rst      (rst),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rlast  (s_rlast),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_count  (m_count),
        .m_err    (m_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mkvec(input int base, input int n);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*64 +: 64] = 64'(base + i);
        return v;
    endfunction

    task automatic drive(input int w0, input int w1, input logic last, input logic [1:0] resp);
        s_rvalid = 1'b1;
        s_rdata  = {64'(w1), 64'(w0)};
        s_rlast  = last;
        s_rresp  = resp;
    endtask

    task automatic idle();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        s_rresp  = 2'b00;
        s_rdata  = '0;
    endtask

    task automatic beat(input int w0, input int w1, input logic last, input logic [1:0] resp);
        drive(w0, w1, last, resp);
        tick();
        idle();
    endtask

    logic exp_err;
    int   idx;
    int   nv;
    int   bad;
    int   lows;

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_s_rready", 512'(s_rready), 512'(1));
        chk("reset_m_valid", 512'(m_valid), 512'(0));
        chk("reset_m_data", m_data, '0);
        chk("reset_m_count", 512'(m_count), 512'(0));
        chk("reset_m_err", 512'(m_err), 512'(0));
        rst = 1'b0;
        tick();

        // full vector: words 0..7, valid appears only after beat 4
        for (int b = 0; b < 3; b++) begin
            beat(2*b, 2*b+1, 1'b0, 2'b00);
            chk($sformatf("full_no_early_valid_%0d", b), 512'(m_valid), 512'(0));
        end
        beat(6, 7, 1'b0, 2'b00);
        chk("full_valid", 512'(m_valid), 512'(1));
        chk("full_data", m_data, mkvec(0, 8));
        chk("full_count", 512'(m_count), 512'(8));
        tick();
        chk("full_drain", 512'(m_valid), 512'(0));

        // partial burst then a fresh full burst starting at word 0
        beat(100, 101, 1'b0, 2'b00);
        beat(102, 103, 1'b1, 2'b00);
        chk("partial_valid", 512'(m_valid), 512'(1));
        chk("partial_count", 512'(m_count), 512'(4));
        chk("partial_data", m_data, mkvec(100, 4));
        for (int b = 0; b < 4; b++) beat(200 + 2*b, 201 + 2*b, 1'b0, 2'b00);
        chk("after_partial_data", m_data, mkvec(200, 8));
        chk("after_partial_count", 512'(m_count), 512'(8));
        tick();

        // backpressure: 8 beats offered while the consumer stalls
        m_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 8; cyc++) begin
            if (idx < 4) drive(300 + 2*idx, 301 + 2*idx, 1'b0, 2'b00);
            else         drive(400 + 2*(idx-4), 401 + 2*(idx-4), 1'b0, 2'b00);
            if (s_rready) idx++;
            tick();
        end
        idle();
        chk("bp_beats_accepted", 512'(idx), 512'(8));
        chk("bp_s_rready_low", 512'(s_rready), 512'(0));
        chk("bp_valid", 512'(m_valid), 512'(1));
        chk("bp_first_data", m_data, mkvec(300, 8));
        tick();
        tick();
        chk("bp_held_stable", m_data, mkvec(300, 8));
        chk("bp_still_low", 512'(s_rready), 512'(0));
        m_ready = 1'b1;
        tick();
        chk("bp_second_valid", 512'(m_valid), 512'(1));
        chk("bp_second_data", m_data, mkvec(400, 8));
        chk("bp_rready_back", 512'(s_rready), 512'(1));
        tick();
        chk("bp_drained", 512'(m_valid), 512'(0));

        // streaming: 64 beats, 16 vectors, no stalls
        nv = 0; bad = 0; lows = 0;
        for (int b = 0; b < 64; b++) begin
            drive(1000 + 2*b, 1001 + 2*b, 1'b0, 2'b00);
            if (!s_rready) lows++;
            tick();
            if (m_valid) begin
                if (m_data !== mkvec(1000 + 8*nv, 8) || m_count !== 4'd8) bad++;
                nv++;
            end
        end
        idle();
        chk("stream_vectors", 512'(nv), 512'(16));
        chk("stream_rready_lows", 512'(lows), 512'(0));
        chk("stream_data_bad", 512'(bad), 512'(0));
        tick();

        // error response on beat 3
`ifdef AXI_WORD_GATHER_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        beat(10, 11, 1'b0, 2'b00);
        beat(12, 13, 1'b0, 2'b00);
        beat(14, 15, 1'b0, 2'b10);
        beat(16, 17, 1'b0, 2'b00);
        chk("err_vec_valid", 512'(m_valid), 512'(1));
        chk("err_vec_flag", 512'(m_err), 512'(exp_err));
        for (int b = 0; b < 4; b++) beat(20 + 2*b, 21 + 2*b, 1'b0, 2'b00);
        chk("err_next_flag", 512'(m_err), 512'(0));
        chk("err_next_data", m_data, mkvec(20, 8));
        tick();

        // reset after 3 beats discards the partial vector
        for (int b = 0; b < 3; b++) beat(600 + 2*b, 601 + 2*b, 1'b0, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (m_valid !== 1'b0) bad++;
        end
        chk("rst_no_output", 512'(bad), 512'(0));
        chk("rst_rready", 512'(s_rready), 512'(1));
        for (int b = 0; b < 4; b++) beat(500 + 2*b, 501 + 2*b, 1'b0, 2'b00);
        chk("rst_fresh_valid", 512'(m_valid), 512'(1));
        chk("rst_fresh_data", m_data, mkvec(500, 8));
        chk("rst_fresh_count", 512'(m_count), 512'(8));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
